clock_divider_ctrl: RTL and testbench
=====================================

// Module: clock_divider_ctrl
// PURPOSE
//  Runtime controller for the programmable counter-based clock divider. Accepts divisor/mode
//  configs over a valid/ready handshake and runs the divider free-running or for a fixed burst.
//  Applies a new config in RUN only at a period boundary, so no period is ever truncated.
//  Feeds tick (1-cycle enable) and clk_out (toggle square wave) to display/timer logic.
// PARAMETERS
//  COUNTER_WIDTH  27          width of divisor and counter
//  DEFAULT_DIV    50_000_000  divisor loaded at reset (cycles per tick)
//  BURST_WIDTH    8           width of burst tick count
// PORTS
//  clk_in     in   1              single system clock, all logic on posedge
//  reset      in   1              synchronous, active-high
//  cfg_valid  in   1              config request
//  cfg_ready  out  1              controller can accept config
//  cfg_mode   in   2              00 stop, 01 free-run, 10 burst, 11 treated as stop
//  cfg_div    in   COUNTER_WIDTH  cycles per tick (0 treated as 1)
//  cfg_count  in   BURST_WIDTH    ticks to emit in burst mode
//  tick       out  1              registered 1-cycle pulse per divisor period
//  clk_out    out  1              registered; toggles on every tick (period = 2*div cycles)
//  busy       out  1              high in RUN or BURST
//  done       out  1              1-cycle pulse when a burst completes
// BEHAVIOUR
//  Reset (sync, priority over all): state=IDLE, counter=0, div_active=DEFAULT_DIV, pending=0,
//   tick=0, clk_out=0, done=0, busy=0; cfg_ready=0 while reset high; handshake ignored.
//  Accept = cfg_valid && cfg_ready at a rising edge; inputs sampled only on that edge.
//  cfg_ready=1 in IDLE, and in RUN when no config pending; 0 in BURST and while pending.
//  States:
//   IDLE : counter held 0, tick=0, clk_out=0. Accept 01 -> RUN, 10 -> BURST (div loaded,
//          counter=0 on the accept edge); 00/11 -> stays IDLE, div unchanged.
//   RUN  : counter +1 per cycle; when counter==div_active-1: counter<=0, tick<=1,
//          clk_out<=~clk_out; else tick<=0. Accept 00/11: immediate -> IDLE on the next edge
//          (counter=0, clk_out=0, tick=0). Accept 01/10: stored in shadow regs, pending=1;
//          applied on the edge that issues the next tick (new div, new mode, burst counter
//          loaded, counter=0); pending cleared the same edge.
//   BURST: counting as RUN; remaining decrements on each tick. On the edge issuing the final
//          tick: tick=1, done=1 same cycle, -> IDLE; clk_out=0 from the following edge.
//          cfg_count=0: no ticks, done pulses one cycle after accept, -> IDLE.
//  Latency: first tick high in cycle after the div-th rising edge following the accept edge;
//   div=1 -> tick high every cycle, clk_out toggles every cycle.
//  busy = (state != IDLE), registered with state. done only ever 1 cycle wide.
//  Counter compares at full COUNTER_WIDTH; no wrap beyond div_active-1; div_active never 0.
//  Reset mid-RUN/BURST or with pending config: all state discarded, no done pulse.
// TESTING
//  1 reset, then mode=01 div=4 -> tick on cycles 4,8,12..; clk_out period 8; busy=1.
//  2 RUN div=4, accept mode=01 div=2 at counter=1 -> cfg_ready=0 until the next tick, no
//    truncated period, then tick every 2 cycles.
//  3 mode=10 div=3 count=5 -> exactly 5 ticks 3 apart, done coincident with 5th, busy falls.
//  4 mode=10 count=0 -> zero ticks, done one cycle after accept; div=0 -> behaves as div=1.
//  5 RUN, accept mode=00 mid-period -> IDLE next edge, tick=0, clk_out=0, cfg_ready=1.
//  6 reset asserted mid-BURST with a pending config -> all outputs at reset values next edge,
//    no done; a fresh config works normally afterwards.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: runtime controller for a counter-based clock divider.
// Takes divisor/mode configs over a valid/ready handshake and runs the
// divider free-running (RUN) or for a fixed number of ticks (BURST).
// Ports:
//   clk_in, reset          : clock, synchronous active-high reset
//   cfg_valid/cfg_ready    : config handshake
//   cfg_mode/div/count     : 00 stop, 01 run, 10 burst, 11 stop;
//                            divisor (0 acts as 1); burst tick count
//   tick, clk_out          : 1-cycle enable, toggle square wave
//   busy, done             : not idle, burst-complete pulse
module clock_divider_ctrl #(
   parameter int COUNTER_WIDTH = 27,
   parameter int DEFAULT_DIV   = 50_000_000,
   parameter int BURST_WIDTH   = 8
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [1:0]               cfg_mode,
   input  logic [COUNTER_WIDTH-1:0] cfg_div,
   input  logic [BURST_WIDTH-1:0]   cfg_count,
   output logic                     tick,
   output logic                     clk_out,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_BURST = 2'd2
   } state_t;

   localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] DIV_RST = COUNTER_WIDTH'(DEFAULT_DIV);
   localparam logic [BURST_WIDTH-1:0] ONE_B = BURST_WIDTH'(1);

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
   logic [COUNTER_WIDTH-1:0] div_active_q, div_active_d;
   logic [BURST_WIDTH-1:0]   remaining_q, remaining_d;
   logic                     pending_q, pending_d;
   logic                     pend_burst_q, pend_burst_d;
   logic [COUNTER_WIDTH-1:0] pend_div_q, pend_div_d;
   logic [BURST_WIDTH-1:0]   pend_count_q, pend_count_d;
   logic                     tick_q, tick_d;
   logic                     clk_out_q, clk_out_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                     accept;
   logic                     is_run_cfg;
   logic                     is_burst_cfg;
   logic                     last;
   logic [COUNTER_WIDTH-1:0] div_eff;

   assign cfg_ready = !reset &&
                      ((state_q == S_IDLE) ||
                       (state_q == S_RUN && !pending_q));

   assign accept       = cfg_valid && cfg_ready;
   assign is_run_cfg   = (cfg_mode == 2'b01);
   assign is_burst_cfg = (cfg_mode == 2'b10);
   assign div_eff      = (cfg_div == '0) ? ONE : cfg_div;
   // div_active is never 0, so div_active-1 cannot underflow
   assign last         = (counter_q == div_active_q - ONE);

   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      div_active_d = div_active_q;
      remaining_d  = remaining_q;
      pending_d    = pending_q;
      pend_burst_d = pend_burst_q;
      pend_div_d   = pend_div_q;
      pend_count_d = pend_count_q;
      tick_d       = 1'b0;
      clk_out_d    = clk_out_q;
      done_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            counter_d = '0;
            clk_out_d = 1'b0;
            if (accept && is_run_cfg) begin
               state_d      = S_RUN;
               div_active_d = div_eff;
            end else if (accept && is_burst_cfg) begin
               state_d      = S_BURST;
               div_active_d = div_eff;
               remaining_d  = cfg_count;
            end
         end

         S_RUN: begin
            if (accept && !is_run_cfg && !is_burst_cfg) begin
               // stop takes effect at once, even on a tick edge
               state_d   = S_IDLE;
               counter_d = '0;
               clk_out_d = 1'b0;
               pending_d = 1'b0;
            end else begin
               if (last) begin
                  counter_d = '0;
                  tick_d    = 1'b1;
                  clk_out_d = ~clk_out_q;
                  // a shadowed config swaps in only on a period boundary
                  if (pending_q) begin
                     pending_d    = 1'b0;
                     div_active_d = pend_div_q;
                     remaining_d  = pend_count_q;
                     state_d      = pend_burst_q ? S_BURST : S_RUN;
                  end
               end else begin
                  counter_d = counter_q + ONE;
               end
               // accept implies no config pending, so no clash above
               if (accept) begin
                  pending_d    = 1'b1;
                  pend_burst_d = is_burst_cfg;
                  pend_div_d   = div_eff;
                  pend_count_d = cfg_count;
               end
            end
         end

         S_BURST: begin
            if (remaining_q == '0) begin
               // zero-length burst: finish without ticking
               state_d   = S_IDLE;
               counter_d = '0;
               clk_out_d = 1'b0;
               done_d    = 1'b1;
            end else if (last) begin
               counter_d   = '0;
               tick_d      = 1'b1;
               clk_out_d   = ~clk_out_q;
               remaining_d = remaining_q - ONE_B;
               if (remaining_q == ONE_B) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               counter_d = counter_q + ONE;
            end
         end

         default: begin
            state_d   = S_IDLE;
            counter_d = '0;
            clk_out_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= S_IDLE;
         counter_q    <= '0;
         div_active_q <= DIV_RST;
         remaining_q  <= '0;
         pending_q    <= 1'b0;
         pend_burst_q <= 1'b0;
         pend_div_q   <= ONE;
         pend_count_q <= '0;
         tick_q       <= 1'b0;
         clk_out_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         counter_q    <= counter_d;
         div_active_q <= div_active_d;
         remaining_q  <= remaining_d;
         pending_q    <= pending_d;
         pend_burst_q <= pend_burst_d;
         pend_div_q   <= pend_div_d;
         pend_count_q <= pend_count_d;
         tick_q       <= tick_d;
         clk_out_q    <= clk_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign tick    = tick_q;
   assign clk_out = clk_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed bench for clock_divider_ctrl.
// Expected tick/done cycles are queued at config time and popped on output.
module tb_clock_divider_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [26:0] cfg_div;
   logic [7:0]  cfg_count;
   logic        tick;
   logic        clk_out;
   logic        busy;
   logic        done;

   int checks;
   int failures;
   int cyc;
   int acc;
   int a, b, c, d, e, f, g;
   int exp_tick[$];
   int exp_done[$];

   clock_divider_ctrl dut (
      .clk_in    (clk),
      .reset     (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mode  (cfg_mode),
      .cfg_div   (cfg_div),
      .cfg_count (cfg_count),
      .tick      (tick),
      .clk_out   (clk_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // scoreboard: every tick/done must match the head of its queue
   always @(negedge clk) begin
      int et;
      int ed;
      if (!rst) begin
         if (tick === 1'b1) begin
            et = (exp_tick.size() > 0) ? exp_tick.pop_front() : -1;
            chk("tick_cycle", cyc, et);
         end
         if (done === 1'b1) begin
            ed = (exp_done.size() > 0) ? exp_done.pop_front() : -1;
            chk("done_cycle", cyc, ed);
         end
      end
   end

   // called at a negedge; returns #1 after the accept edge
   task automatic cfg(input logic [1:0] m, input logic [26:0] dv,
                      input logic [7:0] cn);
      chk("cfg_ready_pre", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_mode  = m;
      cfg_div   = dv;
      cfg_count = cn;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_mode  = 2'b00;
      cfg_div   = '0;
      cfg_count = '0;
      acc = cyc;
   endtask

   task automatic wait_to(input int t);
      @(negedge clk);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_mode  = 2'b00;
      cfg_div   = '0;
      cfg_count = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tick", tick, 0);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cfg_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", cfg_ready, 1);
      chk("idle_busy", busy, 0);

      // free-run div=4
      cfg(2'b01, 27'd4, 8'd0);
      a = acc;
      exp_tick.push_back(a + 4);
      exp_tick.push_back(a + 8);
      exp_tick.push_back(a + 12);
      chk("run_busy", busy, 1);
      wait_to(a + 4);
      chk("run_clk_out_hi", clk_out, 1);
      wait_to(a + 8);
      chk("run_clk_out_lo", clk_out, 0);

      // reconfigure at counter=1: old period completes first
      wait_to(a + 9);
      cfg(2'b01, 27'd2, 8'd0);
      chk("pend_ready0", cfg_ready, 0);
      exp_tick.push_back(a + 14);
      exp_tick.push_back(a + 16);
      wait_to(a + 11);
      chk("pend_ready1", cfg_ready, 0);
      wait_to(a + 12);
      chk("apply_clk_out", clk_out, 1);
      chk("apply_ready", cfg_ready, 1);
      wait_to(a + 14);
      chk("div2_clk_out0", clk_out, 0);
      wait_to(a + 16);
      chk("div2_clk_out1", clk_out, 1);

      // stop mid-period
      cfg(2'b00, 27'd0, 8'd0);
      chk("stop_tick", tick, 0);
      chk("stop_clk_out", clk_out, 0);
      chk("stop_busy", busy, 0);
      chk("stop_ready", cfg_ready, 1);
      repeat (5) @(negedge clk);
      chk("run_ticks_left", exp_tick.size(), 0);

      // burst div=3 count=5
      cfg(2'b10, 27'd3, 8'd5);
      b = acc;
      for (int i = 1; i <= 5; i++) exp_tick.push_back(b + 3 * i);
      exp_done.push_back(b + 15);
      wait_to(b + 1);
      chk("burst_ready", cfg_ready, 0);
      chk("burst_busy", busy, 1);
      wait_to(b + 14);
      chk("burst_busy_late", busy, 1);
      wait_to(b + 15);
      chk("burst_end_busy", busy, 0);
      chk("burst_end_clk", clk_out, 1);
      wait_to(b + 16);
      chk("burst_after_clk", clk_out, 0);
      chk("burst_after_done", done, 0);
      chk("burst_after_ready", cfg_ready, 1);

      // zero-length burst
      cfg(2'b10, 27'd7, 8'd0);
      c = acc;
      exp_done.push_back(c + 1);
      chk("zero_busy", busy, 1);
      chk("zero_done_early", done, 0);
      wait_to(c + 1);
      chk("zero_idle", busy, 0);
      wait_to(c + 4);

      // div=0 acts as div=1
      cfg(2'b10, 27'd0, 8'd3);
      d = acc;
      exp_tick.push_back(d + 1);
      exp_tick.push_back(d + 2);
      exp_tick.push_back(d + 3);
      exp_done.push_back(d + 3);
      wait_to(d + 1);
      chk("div0_clk1", clk_out, 1);
      wait_to(d + 2);
      chk("div0_clk2", clk_out, 0);
      wait_to(d + 4);
      chk("div0_clk_end", clk_out, 0);
      chk("div0_busy_end", busy, 0);

      // reset mid-burst
      cfg(2'b10, 27'd5, 8'd4);
      e = acc;
      exp_tick.push_back(e + 5);
      wait_to(e + 7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_clk", clk_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ready", cfg_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", cfg_ready, 1);

      // reset with a pending config
      cfg(2'b01, 27'd4, 8'd0);
      f = acc;
      wait_to(f + 1);
      cfg(2'b10, 27'd2, 8'd9);
      chk("pend2_ready", cfg_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("pend_rst_busy", busy, 0);
      chk("pend_rst_tick", tick, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("pend_rst_idle", busy, 0);

      // fresh config after reset
      cfg(2'b01, 27'd3, 8'd0);
      g = acc;
      exp_tick.push_back(g + 3);
      exp_tick.push_back(g + 6);
      wait_to(g + 3);
      chk("fresh_clk1", clk_out, 1);
      wait_to(g + 6);
      chk("fresh_clk2", clk_out, 0);
      chk("fresh_ready", cfg_ready, 1);
      cfg(2'b11, 27'd0, 8'd0);
      chk("mode11_busy", busy, 0);
      repeat (4) @(negedge clk);

      chk("tick_q_empty", exp_tick.size(), 0);
      chk("done_q_empty", exp_done.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
